// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with PC, redirect/halt handling and a small fetch FIFO to decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d, fetch_count_q, fetch_count_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [AW:0]     count_q, count_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     pc_mem_q [FIFO_DEPTH];
  logic [31:0]     instr_mem_q [FIFO_DEPTH];
  logic            push, pop;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      misalign_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      misalign_q    <= misalign_d;
      if (push) begin
        pc_mem_q[tail_q]    <= pc_q;
        instr_mem_q[tail_q] <= imem_instr;
      end
    end
  end
  // A redirect never changes the state; it only flushes and reloads the PC.
  always_comb begin
    state_d       = halt ? HALT : RUN;
    pop           = (count_q != '0) && out_ready;
    push          = (state_q == RUN) && !halt && !redirect_valid &&
                    ((count_q < (AW+1)'(FIFO_DEPTH)) || pop);
    pc_d          = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc_q + 32'd4 : pc_q;
    fetch_count_d = fetch_count_q + {31'd0, push};
    head_d        = redirect_valid ? tail_q : head_q + AW'(pop);
    tail_d        = tail_q + AW'(push);
    count_d       = redirect_valid ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    misalign_d    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
  always_comb begin
    imem_addr    = pc_q;
    out_valid    = count_q != '0;
    out_instr    = instr_mem_q[head_q];
    out_pc       = pc_mem_q[head_q];
    misalign_err = misalign_q;
    fetch_count  = fetch_count_q;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction fetch controller that sequences the combinational instruction memory.
- Owns the PC and drives the memory address every cycle.
- Captures each returned word together with its PC into a small FIFO and presents it to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush and reload PC), halt requests and misaligned-target detection.
- Sits between the instruction memory and the decode stage of the CPU datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FIFO_DEPTH, 2, fetch buffer entries; power of two, at least 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
imem_addr  output  32  byte address to instruction memory; equals the current PC register
imem_instr  input  32  instruction word returned combinationally for imem_addr
redirect_valid  input  1  load new PC this cycle (branch/jump taken)
redirect_pc  input  32  redirect target byte address
halt  input  1  suspend fetching; buffered entries still drain
out_valid  output  1  head entry valid
out_instr  output  32  head instruction
out_pc  output  32  PC of head instruction
out_ready  input  1  decode accepts head when out_valid=1
misalign_err  output  1  one-cycle pulse: last redirect target had [1:0]!=0
fetch_count  output  32  total words pushed into the FIFO, wraps modulo 2^32

Behaviour:
- Reset (rst=1 at a clock edge), synchronous only:
  - pc=RESET_PC; FIFO count=0; all FIFO entries cleared; FSM=BOOT.
  - Outputs: out_valid=0, out_instr=0, out_pc=0, misalign_err=0, fetch_count=0, imem_addr=RESET_PC.
  - Reset asserted mid-operation discards all buffered entries and any redirect in the same cycle.
- FSM states:
  - BOOT: one cycle after reset release, no push. Always goes to RUN next cycle; goes to HALT instead if halt=1.
  - RUN: fetching. Goes to HALT when halt=1.
  - HALT: no push, pc held. Goes to RUN when halt=0.
- Push condition, evaluated each cycle: state=RUN, halt=0, redirect_valid=0, and (count<FIFO_DEPTH or a pop occurs this cycle). On push, {pc, imem_instr} is written at the tail, pc<=pc+4 (wraps 32'hFFFF_FFFC -> 0), fetch_count++.
- Pop: out_valid && out_ready. Head advances.
- out_valid = (count!=0). out_instr/out_pc show the head entry, driven from registers.
- Latency: a word fetched at edge N is visible on out_* after edge N.
- Throughput: one word per cycle while out_ready=1, including when the FIFO is full, because push and pop may occur in the same cycle.
- Redirect (redirect_valid=1) has priority over push:
  - FIFO flushed (count=0).
  - pc<={redirect_pc[31:2],2'b00}.
  - No push that cycle.
  - A pop in the same cycle is a completed transfer to decode; the FIFO is still emptied.
  - Redirect takes effect in BOOT and HALT as well; the state is unchanged by a redirect.
- misalign_err is registered: it equals 1 for exactly the cycle after a redirect with redirect_pc[1:0]!=0, otherwise 0.
- Halt does not clear the FIFO; the consumer may continue popping during HALT.
- Head/tail pointers wrap modulo FIFO_DEPTH. count never exceeds FIFO_DEPTH and never underflows; a pop with count=0 cannot occur because out_valid=0.

Test Plan:
- Sequential fetch: reset 2 cycles, imem returns addr^32'hA5A5_0000, out_ready=1.
  - First out_valid 2 cycles after reset release with out_pc=0, out_instr=32'hA5A5_0000.
  - Then out_pc 4, 8, 12 on consecutive cycles; fetch_count increments by 1 per cycle.
- Backpressure: out_ready=0 from reset.
  - count reaches 2, imem_addr holds 8, fetch_count=2, out_pc stays 0.
  - Raise out_ready: outputs 0, 4, 8 back-to-back with no bubble.
- Redirect: pulse redirect_valid with redirect_pc=32'h40 while 2 entries are buffered.
  - Next cycle out_valid=0.
  - Following cycle out_pc=32'h40; the old entries are never presented.
- Misaligned redirect: redirect_pc=32'h43.
  - pc becomes 32'h40; misalign_err=1 for exactly one cycle; first out_pc=32'h40.
- Halt/wrap: force pc to 32'hFFFF_FFFC via redirect, then assert halt after one push.
  - Buffered entry drains; imem_addr holds 0; fetch_count is frozen.
  - Release halt: next out_pc=0.
- Reset mid-operation: assert rst with a full FIFO and redirect_valid=1.
  - Next cycle out_valid=0, imem_addr=RESET_PC, fetch_count=0, misalign_err=0.
